audio_serializer: RTL
=====================

Name: audio_serializer

Overview:
- Downstream consumer of the 24-bit sign-extended audio samples; buffers them in a small FIFO.
- Serialises them to the codec DAC as an I2S stream: bclk, lrclk and sdata generated from the system clock.
- Single clock domain; bclk is a registered divided output, not a clock for any internal logic.
- Flags slots that could not be filled (underrun or channel mismatch).

Parameters:
- WIDTH, 24: sample width; matches the sign-extender output.
- SLOT_BITS, 32: bclk periods per channel slot; must be >= WIDTH+1.
- BCLK_DIV, 4: clk cycles per bclk half-period; must be >= 1.
- FIFO_DEPTH, 4: sample FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sample_in  in  WIDTH  two's-complement sample.
- sample_ch  in  1  channel tag: 0 = left, 1 = right.
- sample_valid  in  1  sample_in/sample_ch are valid.
- sample_ready  out  1  FIFO can accept; equals !full.
- bclk  out  1  serial bit clock.
- lrclk  out  1  word select: 0 = left slot, 1 = right slot.
- sdata  out  1  serial data, MSB first.
- underrun  out  1  one-clk pulse at a slot start that carries no valid sample.

Behaviour:
- Clock and reset:
  - Reset is synchronous, active-high, single clock clk.
  - On reset: bclk=0, lrclk=0, sdata=0, underrun=0, FIFO emptied, sample_ready=1 on the following cycle.
  - Divider reset to 0. Slot channel reset to left; bit counter set so the first falling edge opens left slot period 0.
  - Reset mid-frame abandons the current slot immediately; buffered samples are discarded.
- Push handshake:
  - Push occurs when sample_valid && sample_ready; FIFO stores {sample_ch, sample_in}.
  - sample_ready is registered and low when count == FIFO_DEPTH.
- bclk generation:
  - A divider counts 0..BCLK_DIV-1 and toggles bclk at terminal count.
  - bclk period = 2*BCLK_DIV clk. All sdata/lrclk changes occur in the same clk as a bclk 1->0 transition (the falling event).
- Slot structure:
  - Period index p runs 0..SLOT_BITS-1 and advances on each falling event.
  - The slot start is the falling event where p wraps to 0. At slot start:
    - lrclk = slot channel, which alternates L, R, L, ...
    - sdata = 0 (I2S one-bit delay).
    - The shift register is loaded.
  - p = 1..WIDTH: sdata = sample bit WIDTH-p (MSB first).
  - p = WIDTH+1..SLOT_BITS-1: sdata = 0.
  - Frame = 2*SLOT_BITS bclk periods = 512 clk at defaults.
- Load decision at slot start, evaluated on the registered FIFO state before that clk:
  - FIFO non-empty and head tag == slot channel: pop, load head sample.
  - FIFO non-empty and tag mismatch: pop and discard head, load 0, pulse underrun.
  - FIFO empty: load 0, pulse underrun, no pop.
- Simultaneous events:
  - Push and pop in the same clk: count unchanged.
  - Push into an empty FIFO in the slot-start clk is not visible to that slot; it is an underrun for that slot and the sample is used from the next matching slot.
- Latency: a sample at the FIFO head at a matching slot start puts its MSB on sdata exactly 2*BCLK_DIV clk after that slot start.
- Wrap-around: FIFO pointers wrap modulo FIFO_DEPTH; the slot channel toggles each slot indefinitely.

Optional Feature:
- Macro: AUDIO_SERIALIZER_HOLD_LAST_EN.
- Defined: keep a last-sample register per channel, updated on every successful load and cleared by reset. On underrun or mismatch, that channel's last sample is reloaded instead of 0. The underrun pulse is still generated.
- Undefined: registers are absent and 0 is sent, as above.

Test Plan:
- Reset: hold reset 3 clk mid-slot -> bclk/lrclk/sdata/underrun = 0 from the next clk, sample_ready = 1, first slot start is left at 2*BCLK_DIV clk after reset release.
- Stereo data: push L=24'hA5A5A5 (ch 0) and R=24'h00F00F (ch 1) before the first slot, BCLK_DIV=2 -> left slot sdata = 0, then 1010_0101 x3, then 7 zeros. Right slot with lrclk=1 carries 24'h00F00F. No underrun.
- Empty FIFO: no pushes for 2 frames -> sdata constantly 0, underrun pulses once per slot (4 pulses), lrclk still alternates.
- Full: push 4 samples between slot starts -> sample_ready = 0 after the 4th. A 5th valid is held off and accepted the clk after the next pop.
- Mismatch: push only R=24'h000001 before a left slot -> left slot sends 0 with an underrun pulse and the entry is discarded; the following right slot underruns too.
- HOLD_LAST: with the macro defined, after L=24'h123456 is played, an empty left slot -> sdata repeats 24'h123456 and underrun still pulses.

Source files
------------

// File: rtl/audio_serializer.sv
// audio_serializer: FIFO-buffered I2S transmitter; bclk/lrclk/sdata are registered outputs derived from clk.
// Define AUDIO_SERIALIZER_HOLD_LAST_EN to repeat each channel's last sample instead of zero on underrun.
module audio_serializer #(
  parameter int WIDTH      = 24,
  parameter int SLOT_BITS  = 32,
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_ch,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             bclk,
  output logic             lrclk,
  output logic             sdata,
  output logic             underrun
);
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int P_W   = $clog2(SLOT_BITS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [DIV_W-1:0] DIV_TC     = DIV_W'(BCLK_DIV - 1);
  localparam logic [P_W-1:0]   P_LAST     = P_W'(SLOT_BITS - 1);
  localparam logic [P_W-1:0]   P_DATA_END = P_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);

  logic [WIDTH:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [P_W-1:0]   p_q, p_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             bclk_q, bclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d;
  logic             underrun_q, underrun_d, slot_ch_q, slot_ch_d;
  logic             div_tc, fall, slot_start, fifo_empty, head_match, push, pop;
  logic [WIDTH:0]   head;
  logic [WIDTH-1:0] fill;
`ifdef AUDIO_SERIALIZER_HOLD_LAST_EN
  logic [WIDTH-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
`endif

  always_comb begin
    div_tc     = (div_q == DIV_TC);
    fall       = div_tc && bclk_q;
    slot_start = fall && (p_q == P_LAST);
    head       = mem_q[rd_ptr_q];
    fifo_empty = (count_q == '0);
    head_match = !fifo_empty && (head[WIDTH] == slot_ch_q);
    push       = sample_valid && ready_q;
    // a mismatching head is popped and dropped just like a matching one
    pop        = slot_start && !fifo_empty;
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    div_d      = div_tc ? '0 : div_q + DIV_W'(1);
    bclk_d     = div_tc ? !bclk_q : bclk_q;
`ifdef AUDIO_SERIALIZER_HOLD_LAST_EN
    fill       = slot_ch_q ? last_r_q : last_l_q;
    last_l_d   = last_l_q;
    last_r_d   = last_r_q;
`else
    fill       = '0;
`endif
    p_d        = p_q;
    shreg_d    = shreg_q;
    sdata_d    = sdata_q;
    lrclk_d    = lrclk_q;
    slot_ch_d  = slot_ch_q;
    underrun_d = 1'b0;
    if (fall) begin
      if (p_q == P_LAST) begin
        p_d       = '0;
        lrclk_d   = slot_ch_q;
        sdata_d   = 1'b0;
        slot_ch_d = !slot_ch_q;
        if (head_match) begin
          shreg_d = head[WIDTH-1:0];
`ifdef AUDIO_SERIALIZER_HOLD_LAST_EN
          if (slot_ch_q) last_r_d = head[WIDTH-1:0];
          else           last_l_d = head[WIDTH-1:0];
`endif
        end else begin
          shreg_d    = fill;
          underrun_d = 1'b1;
        end
      end else begin
        p_d = p_q + P_W'(1);
        if (p_d <= P_DATA_END) begin
          sdata_d = shreg_q[WIDTH-1];
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
          sdata_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {sample_ch, sample_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b1;
      div_q      <= '0;
      p_q        <= P_LAST;
      shreg_q    <= '0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
      slot_ch_q  <= 1'b0;
`ifdef AUDIO_SERIALIZER_HOLD_LAST_EN
      last_l_q   <= '0;
      last_r_q   <= '0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_q    <= (count_d != CNT_FULL);
      div_q      <= div_d;
      p_q        <= p_d;
      shreg_q    <= shreg_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
      slot_ch_q  <= slot_ch_d;
`ifdef AUDIO_SERIALIZER_HOLD_LAST_EN
      last_l_q   <= last_l_d;
      last_r_q   <= last_r_d;
`endif
    end
  end

  assign sample_ready = ready_q;
  assign bclk         = bclk_q;
  assign lrclk        = lrclk_q;
  assign sdata        = sdata_q;
  assign underrun     = underrun_q;
endmodule
